// File: rtl/bcd_to_binary_transcoder_if.sv
// Operand/result bundle for the BCD-to-binary transcoder.
// The master side supplies operands; the slave side (the transcoder) returns results.
interface bcd_to_binary_transcoder_if #(
    parameter int unsigned DIGITS = 3
);
    localparam int unsigned IN_WIDTH  = DIGITS * 4;
    localparam int unsigned OUT_WIDTH = $clog2(10 ** DIGITS);

    logic [IN_WIDTH-1:0]  in;
    logic                 in_valid;
    logic                 in_ready;
    logic [OUT_WIDTH-1:0] out;
    logic                 out_valid;
    logic                 out_error;

    modport master (
        output in, in_valid,
        input  in_ready, out, out_valid, out_error
    );

    modport slave (
        input  in, in_valid,
        output in_ready, out, out_valid, out_error
    );
endinterface

// File: rtl/bcd_to_binary_transcoder.sv
// Packed-BCD to binary converter using reverse double-dabble (shift right, subtract 3),
// producing one result bit per clock with a one-cycle result strobe.
module bcd_to_binary_transcoder #(
    parameter int unsigned DIGITS = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    bcd_to_binary_transcoder_if.slave        bus
);
    localparam int unsigned IN_WIDTH  = DIGITS * 4;
    localparam int unsigned OUT_WIDTH = $clog2(10 ** DIGITS);
    localparam int unsigned CNT_W     = $clog2(OUT_WIDTH + 1);
    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(OUT_WIDTH);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    typedef enum logic {StIdle, StShift} state_t;

    state_t                r_state, w_state_nxt;
    logic [IN_WIDTH-1:0]   r_bcd, w_bcd_nxt;
    logic [OUT_WIDTH-1:0]  r_bin, w_bin_nxt;
    logic                  r_err, w_err_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [OUT_WIDTH-1:0]  r_out, w_out_nxt;
    logic                  r_out_valid, w_out_valid_nxt;
    logic                  r_out_error, w_out_error_nxt;

    logic [IN_WIDTH+OUT_WIDTH-1:0] w_shift;
    logic [IN_WIDTH-1:0]           w_bcd_sh;
    logic [IN_WIDTH-1:0]           w_bcd_corr;
    logic [OUT_WIDTH-1:0]          w_bin_sh;
    logic                          w_in_bad;

    assign w_shift  = {r_bcd, r_bin} >> 1;
    assign w_bcd_sh = w_shift[IN_WIDTH+OUT_WIDTH-1:OUT_WIDTH];
    assign w_bin_sh = w_shift[OUT_WIDTH-1:0];

    // Undo the x2 of decimal digits: any digit >= 8 after the halving absorbed a 10 from above.
    always_comb begin
        w_bcd_corr = w_bcd_sh;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (w_bcd_sh[4*i +: 4] >= 4'd8) begin
                w_bcd_corr[4*i +: 4] = w_bcd_sh[4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        w_in_bad = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bus.in[4*i +: 4] > 4'd9) begin
                w_in_bad = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_bcd_nxt       = r_bcd;
        w_bin_nxt       = r_bin;
        w_err_nxt       = r_err;
        w_cnt_nxt       = r_cnt;
        w_out_nxt       = r_out;
        w_out_valid_nxt = 1'b0;
        w_out_error_nxt = r_out_error;
        unique case (r_state)
            StIdle: begin
                if (bus.in_valid) begin
                    w_bcd_nxt   = bus.in;
                    w_bin_nxt   = '0;
                    w_err_nxt   = w_in_bad;
                    w_cnt_nxt   = CntLoad;
                    w_state_nxt = StShift;
                end
            end
            StShift: begin
                w_bcd_nxt = w_bcd_corr;
                w_bin_nxt = w_bin_sh;
                w_cnt_nxt = r_cnt - CntOne;
                if (r_cnt == CntOne) begin
                    w_out_nxt       = r_err ? '0 : w_bin_sh;
                    w_out_error_nxt = r_err;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_bcd       <= '0;
            r_bin       <= '0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_out_error <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bcd       <= w_bcd_nxt;
            r_bin       <= w_bin_nxt;
            r_err       <= w_err_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_error <= w_out_error_nxt;
        end
    end

    assign bus.in_ready  = (r_state == StIdle);
    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.out_error = r_out_error;
endmodule

// File: tb/tb_bcd_to_binary_transcoder.sv
// Bench for bcd_to_binary_transcoder: directed scenarios plus random operands checked
// against a decimal-arithmetic reference model.
module tb_bcd_to_binary_transcoder;
    localparam int DIG = 3;
    localparam int IW  = DIG * 4;
    localparam int OW  = 10;
    localparam int LAT = OW;

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    bcd_to_binary_transcoder_if #(.DIGITS(DIG)) bus ();

    bcd_to_binary_transcoder #(.DIGITS(DIG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: read the digits as a decimal number; any digit above 9 makes it illegal.
    function automatic void model(input logic [IW-1:0] v, output int val, output bit err);
        int mult;
        int d;
        val  = 0;
        err  = 1'b0;
        mult = 1;
        for (int i = 0; i < DIG; i++) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) err = 1'b1;
            val  = val + d * mult;
            mult = mult * 10;
        end
        if (err) val = 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents v for one edge (the acceptance edge) and returns #1 after it.
    task automatic accept(input logic [IW-1:0] v);
        bus.in       = v;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Watches max_n edges after acceptance; records the first strobe and ready-while-busy events.
    task automatic collect(input int max_n, output int first_n, output int strobes,
                           output logic [OW-1:0] o, output logic e, output int busy_ready);
        first_n    = -1;
        strobes    = 0;
        o          = '0;
        e          = 1'b0;
        busy_ready = bus.in_ready ? 1 : 0;
        for (int n = 1; n <= max_n; n++) begin
            tick();
            if (n < LAT && bus.in_ready) busy_ready++;
            if (bus.out_valid) begin
                strobes++;
                if (first_n < 0) begin
                    first_n = n;
                    o       = bus.out;
                    e       = bus.out_error;
                end
            end
        end
    endtask

    task automatic test_reset();
        int bad_cycles;
        reset        = 1'b1;
        bus.in       = '0;
        bus.in_valid = 1'b0;
        tick();
        tick();
        reset      = 1'b0;
        bad_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if (bus.in_ready !== 1'b1 || bus.out !== '0 || bus.out_valid !== 1'b0 ||
                bus.out_error !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_idle cycle %0d: got ready=%b out=%0d valid=%b err=%b want 1/0/0/0",
                         i, bus.in_ready, bus.out, bus.out_valid, bus.out_error);
            end
        end
    endtask

    task automatic test_single();
        int fn, st, br;
        logic [OW-1:0] o;
        logic e;
        accept(12'h255);
        collect(20, fn, st, o, e, br);
        n_cmp++;
        if (fn !== LAT) begin n_bad++; $display("FAIL single_latency: got %0d want %0d", fn, LAT); end
        n_cmp++;
        if (st !== 1) begin n_bad++; $display("FAIL single_strobes: got %0d want 1", st); end
        n_cmp++;
        if (o !== 10'd255) begin n_bad++; $display("FAIL single_out: got %0d want 255", o); end
        n_cmp++;
        if (e !== 1'b0) begin n_bad++; $display("FAIL single_err: got %b want 0", e); end
        n_cmp++;
        if (br !== 0) begin n_bad++; $display("FAIL single_busy_ready: got %0d want 0", br); end
        n_cmp++;
        if (bus.out !== 10'd255) begin
            n_bad++;
            $display("FAIL single_out_hold: got %0d want 255", bus.out);
        end
    endtask

    task automatic test_back_to_back();
        int t[2];
        logic [OW-1:0] v[2];
        int k;
        k = 0;
        bus.in       = 12'h999;
        bus.in_valid = 1'b1;
        tick();
        bus.in = 12'h000;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (n == 10) begin
                n_cmp++;
                if (bus.in_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_ready_in_strobe: got %b want 1", bus.in_ready);
                end
            end
            if (n == 11) bus.in_valid = 1'b0;
            if (bus.out_valid) begin
                if (k < 2) begin
                    t[k] = n;
                    v[k] = bus.out;
                end
                k++;
            end
        end
        n_cmp++;
        if (k !== 2) begin
            n_bad++;
            $display("FAIL b2b_strobes: got %0d want 2", k);
        end else begin
            n_cmp++;
            if (t[0] !== LAT) begin n_bad++; $display("FAIL b2b_first_time: got %0d want %0d", t[0], LAT); end
            n_cmp++;
            if (t[1] - t[0] !== LAT + 1) begin
                n_bad++;
                $display("FAIL b2b_spacing: got %0d want %0d", t[1] - t[0], LAT + 1);
            end
            n_cmp++;
            if (v[0] !== 10'd999) begin n_bad++; $display("FAIL b2b_out999: got %0d want 999", v[0]); end
            n_cmp++;
            if (v[1] !== 10'd0) begin n_bad++; $display("FAIL b2b_out000: got %0d want 0", v[1]); end
        end
    endtask

    task automatic test_error();
        int fn, st, br;
        logic [OW-1:0] o;
        logic e;
        accept(12'h1A3);
        collect(15, fn, st, o, e, br);
        n_cmp++;
        if (o !== '0 || e !== 1'b1) begin
            n_bad++;
            $display("FAIL err_result: got out=%0d err=%b want out=0 err=1", o, e);
        end
        n_cmp++;
        if (st !== 1) begin n_bad++; $display("FAIL err_strobes: got %0d want 1", st); end
        accept(12'h042);
        collect(12, fn, st, o, e, br);
        n_cmp++;
        if (o !== 10'd42 || e !== 1'b0) begin
            n_bad++;
            $display("FAIL err_recover: got out=%0d err=%b want out=42 err=0", o, e);
        end
    endtask

    task automatic test_reset_mid();
        int fn, st, br;
        logic [OW-1:0] o;
        logic e;
        int strobes;
        strobes = 0;
        accept(12'h512);
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (bus.out_valid) strobes++;
            if (n == 4) reset = 1'b1;
            if (n == 5) begin
                reset = 1'b0;
                n_cmp++;
                if (bus.out !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL rstmid_after: got out=%0d valid=%b ready=%b want 0/0/1",
                             bus.out, bus.out_valid, bus.in_ready);
                end
            end
            if (n == 6) begin
                n_cmp++;
                if (bus.in_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL rstmid_ready: got %b want 1", bus.in_ready);
                end
            end
        end
        n_cmp++;
        if (strobes !== 0) begin n_bad++; $display("FAIL rstmid_strobes: got %0d want 0", strobes); end
        accept(12'h007);
        collect(12, fn, st, o, e, br);
        n_cmp++;
        if (o !== 10'd7 || e !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_next: got out=%0d err=%b want out=7 err=0", o, e);
        end
    endtask

    task automatic test_busy_pulse();
        int strobes;
        logic [OW-1:0] first;
        strobes = 0;
        first   = '0;
        accept(12'h300);
        for (int n = 1; n <= 25; n++) begin
            if (n == 3) begin
                bus.in       = 12'h123;
                bus.in_valid = 1'b1;
            end
            if (n == 4) bus.in_valid = 1'b0;
            tick();
            if (bus.out_valid) begin
                if (strobes == 0) first = bus.out;
                strobes++;
            end
        end
        n_cmp++;
        if (strobes !== 1) begin n_bad++; $display("FAIL busy_strobes: got %0d want 1", strobes); end
        n_cmp++;
        if (first !== 10'd300) begin n_bad++; $display("FAIL busy_out: got %0d want 300", first); end
    endtask

    task automatic test_random();
        int fn, st, br;
        logic [OW-1:0] o;
        logic e;
        logic [IW-1:0] v;
        int exp_val;
        bit exp_err;
        for (int it = 0; it < 40; it++) begin
            for (int d = 0; d < DIG; d++) begin
                v[4*d +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                          : 4'($urandom_range(0, 9));
            end
            model(v, exp_val, exp_err);
            accept(v);
            collect(LAT + 1, fn, st, o, e, br);
            n_cmp++;
            if (int'(o) !== exp_val || e !== exp_err || fn !== LAT || st !== 1) begin
                n_bad++;
                $display("FAIL random in=%h: got out=%0d err=%b at=%0d n=%0d want out=%0d err=%b at=%0d n=1",
                         v, o, e, fn, st, exp_val, exp_err, LAT);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.in       = '0;
        bus.in_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_error();
        test_reset_mid();
        test_busy_pulse();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
